// File: rtl/resync_reader.sv
// Burst reader that pulls words from a registered-output FIFO into a two-entry skid buffer
// with a registered valid/ready output. Optional WAIT_VALID timeout: define RESYNC_READER_TIMEOUT_EN.
module resync_reader #(
  parameter int unsigned           DATA_WIDTH    = 16,
  parameter int unsigned           LEN_WIDTH     = 16,
  parameter logic [DATA_WIDTH-1:0] INITIAL_VALUE = '0,
  parameter int unsigned           TIMEOUT       = 1023
) (
  input  logic                  rclk,
  input  logic                  arst_n,
  input  logic                  srst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic                  fifo_valid,
  output logic                  fifo_re,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {IDLE, WAIT_VALID, READ, DRAIN, DONE} state_t;

  state_t                state;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [LEN_WIDTH-1:0]  remaining_nxt;
  logic                  rd_inflight;
  logic                  skid_valid;
  logic [DATA_WIDTH-1:0] skid_data;
  logic                  pop;
  logic [1:0]            held;
  logic [1:0]            pending;
  logic                  credit_ok;
  logic                  drain_empty;
  logic                  timeout_hit;

  // out_data is the head entry of the skid buffer, skid_data the second; a read is only
  // issued when its word is guaranteed a free slot on arrival.
  assign pop           = out_valid && out_ready;
  assign held          = 2'(out_valid) + 2'(skid_valid);
  assign pending       = held + 2'(rd_inflight);
  assign credit_ok     = (pending - 2'(pop)) <= 2'd1;
  assign fifo_re       = (state == READ) && (remaining != '0) && credit_ok;
  assign remaining_nxt = remaining - LEN_WIDTH'(fifo_re);
  assign drain_empty   = !rd_inflight && ((held - 2'(pop)) == 2'd0);

`ifdef RESYNC_READER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] wait_cnt;

  assign timeout_hit = (wait_cnt == TW'(TIMEOUT));

  always_ff @(posedge rclk or negedge arst_n) begin
    if (!arst_n) begin
      wait_cnt <= '0;
      error    <= 1'b0;
    end else if (srst) begin
      wait_cnt <= '0;
      error    <= 1'b0;
    end else begin
      if (state == WAIT_VALID && !fifo_valid && !timeout_hit)
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;
      if (state == IDLE && start)
        error <= 1'b0;
      else if (state == WAIT_VALID && !fifo_valid && timeout_hit)
        error <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign error       = 1'b0;
`endif

  always_ff @(posedge rclk or negedge arst_n) begin
    if (!arst_n) begin
      state     <= IDLE;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (srst) begin
      state     <= IDLE;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done      <= 1'b0;
      remaining <= remaining_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (len != '0) begin
              state     <= WAIT_VALID;
              remaining <= len;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        WAIT_VALID: begin
          if (fifo_valid) begin
            state <= READ;
          end else if (timeout_hit) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        READ: begin
          if (remaining_nxt == '0)
            state <= DRAIN;
        end
        DRAIN: begin
          if (drain_empty) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // A word in flight at reset is dropped because rd_inflight is cleared with everything else.
  always_ff @(posedge rclk or negedge arst_n) begin
    if (!arst_n) begin
      rd_inflight <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= INITIAL_VALUE;
      skid_valid  <= 1'b0;
      skid_data   <= '0;
    end else if (srst) begin
      rd_inflight <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= INITIAL_VALUE;
      skid_valid  <= 1'b0;
      skid_data   <= '0;
    end else begin
      rd_inflight <= fifo_re;
      if (!out_valid || pop) begin
        if (skid_valid) begin
          out_data   <= skid_data;
          out_valid  <= 1'b1;
          skid_valid <= rd_inflight;
          if (rd_inflight)
            skid_data <= fifo_data;
        end else if (rd_inflight) begin
          out_data  <= fifo_data;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (rd_inflight) begin
        skid_data  <= fifo_data;
        skid_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_resync_reader.sv
// Scoreboard bench for resync_reader: a FIFO model supplies words, expected words are queued
// at burst start and popped on each output handshake.
module tb_resync_reader;

  localparam logic [15:0] INIT_VAL = 16'h5A5A;
`ifdef RESYNC_READER_TIMEOUT_EN
  localparam int VLOW_CYCLES = 10;
`else
  localparam int VLOW_CYCLES = 20;
`endif

  logic        rclk = 1'b0;
  logic        arst_n, srst, start, fifo_valid, fifo_re, out_valid, out_ready;
  logic        busy, done, error;
  logic [15:0] len, fifo_data, out_data;

  resync_reader #(
    .DATA_WIDTH(16), .LEN_WIDTH(16), .INITIAL_VALUE(INIT_VAL), .TIMEOUT(15)
  ) dut (
    .rclk(rclk), .arst_n(arst_n), .srst(srst), .start(start), .len(len),
    .fifo_valid(fifo_valid), .fifo_re(fifo_re), .fifo_data(fifo_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .error(error)
  );

  always #5 rclk = ~rclk;

  logic [15:0] mem [0:255];
  int          rd_ptr = 0;
  int          exp_ptr = 0;
  logic [15:0] exp_q [$];

  int assert_count = 0;
  int fail_count = 0;
  int cyc = 0;
  int t0 = 0;
  int re_cnt, acc_cnt, done_cnt, busy_cnt, first_re, first_valid, last_valid, done_rel;
  int reads_tot = 0;
  int acc_tot = 0;
  logic error_at_done;
  logic [3:0] ready_pat = 4'b1001;

  // Registered-output FIFO model: data appears the cycle after fifo_re.
  always @(posedge rclk) begin
    cyc <= cyc + 1;
    if (fifo_re) begin
      fifo_data <= mem[rd_ptr % 256];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Monitor: credit, scoreboard and timing bookkeeping, sampled mid-cycle.
  always @(negedge rclk) begin
    int rel;
    logic [15:0] exp_word;
    rel = cyc - t0;
    if (arst_n && !srst) begin
      if (fifo_re) begin
        checkOutput("credit", 32'((reads_tot - acc_tot - ((out_valid && out_ready) ? 1 : 0)) <= 1), 32'd1);
        if (re_cnt == 0) first_re = rel;
        re_cnt++;
        reads_tot++;
      end
      if (out_valid) begin
        if (first_valid < 0) first_valid = rel;
        last_valid = rel;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("sb_underflow", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          exp_word = exp_q.pop_front();
          checkOutput("word", 32'(out_data), 32'(exp_word));
        end
        acc_cnt++;
        acc_tot++;
      end
      if (done) begin
        done_cnt++;
        done_rel = rel;
        error_at_done = error;
      end
      if (busy) busy_cnt++;
    end
  end

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic clear_stats();
    re_cnt = 0; acc_cnt = 0; done_cnt = 0; busy_cnt = 0;
    first_re = -1; first_valid = -1; last_valid = -1; done_rel = -1;
  endtask

  task automatic applyStimulus(input logic [15:0] burst_len);
    clear_stats();
    for (int i = 0; i < int'(burst_len); i++) begin
      exp_q.push_back(mem[exp_ptr % 256]);
      exp_ptr++;
    end
    start = 1'b1;
    len   = burst_len;
    t0    = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles, input bit toggle);
    for (int k = 0; k < max_cycles; k++) begin
      if (done_cnt > 0) break;
      tick();
      if (toggle) out_ready = ready_pat[k % 4];
    end
    checkOutput("done_reached", 32'(done_cnt > 0), 32'd1);
    out_ready = 1'b1;
    tick();
    tick();
  endtask

  task automatic resync_scoreboard();
    exp_q.delete();
    exp_ptr   = rd_ptr;
    reads_tot = acc_tot;
  endtask

  initial begin
    int vrise;
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 16'h03B1 + 16'h1234);
    arst_n = 1'b0; srst = 1'b0; start = 1'b0; len = '0;
    fifo_valid = 1'b0; out_ready = 1'b1;
    clear_stats();
    repeat (3) tick();
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'(INIT_VAL));
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_error", 32'(error), 32'd0);
    checkOutput("rst_fifo_re", 32'(fifo_re), 32'd0);
    arst_n = 1'b1;
    tick();

    $display("[TB] basic burst len=4");
    fifo_valid = 1'b1;
    applyStimulus(16'd4);
    wait_done(40, 1'b0);
    checkOutput("b4_first_re", 32'(first_re), 32'd2);
    checkOutput("b4_first_valid", 32'(first_valid), 32'd4);
    checkOutput("b4_last_valid", 32'(last_valid), 32'd7);
    checkOutput("b4_done_cycle", 32'(done_rel), 32'd8);
    checkOutput("b4_re_count", 32'(re_cnt), 32'd4);
    checkOutput("b4_words", 32'(acc_cnt), 32'd4);
    checkOutput("b4_done_count", 32'(done_cnt), 32'd1);
    checkOutput("b4_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] backpressure burst len=8");
    applyStimulus(16'd8);
    wait_done(80, 1'b1);
    checkOutput("bp_re_count", 32'(re_cnt), 32'd8);
    checkOutput("bp_words", 32'(acc_cnt), 32'd8);
    checkOutput("bp_done_count", 32'(done_cnt), 32'd1);
    checkOutput("bp_sb_empty", 32'(exp_q.size()), 32'd0);
    checkOutput("bp_idle", 32'(busy), 32'd0);

    $display("[TB] zero-length burst");
    applyStimulus(16'd0);
    wait_done(10, 1'b0);
    checkOutput("z_re_count", 32'(re_cnt), 32'd0);
    checkOutput("z_done_cycle", 32'(done_rel), 32'd1);
    checkOutput("z_busy_cycles", 32'(busy_cnt), 32'd1);

    $display("[TB] late fifo_valid, len=3");
    fifo_valid = 1'b0;
    applyStimulus(16'd3);
    repeat (VLOW_CYCLES - 1) tick();
    checkOutput("lv_no_re_yet", 32'(re_cnt), 32'd0);
    fifo_valid = 1'b1;
    vrise = cyc - t0;
    wait_done(40, 1'b0);
    checkOutput("lv_first_re", 32'(first_re), 32'(vrise + 1));
    checkOutput("lv_words", 32'(acc_cnt), 32'd3);
    checkOutput("lv_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] async reset mid-burst");
    applyStimulus(16'd6);
    for (int k = 0; k < 40 && acc_cnt < 2; k++) tick();
    checkOutput("ar_two_words", 32'(acc_cnt), 32'd2);
    arst_n = 1'b0;
    #1;
    checkOutput("ar_out_valid", 32'(out_valid), 32'd0);
    checkOutput("ar_out_data", 32'(out_data), 32'(INIT_VAL));
    checkOutput("ar_busy", 32'(busy), 32'd0);
    checkOutput("ar_fifo_re", 32'(fifo_re), 32'd0);
    checkOutput("ar_done", 32'(done), 32'd0);
    tick();
    tick();
    arst_n = 1'b1;
    resync_scoreboard();
    repeat (4) tick();
    checkOutput("ar_no_done", 32'(done_cnt), 32'd0);
    checkOutput("ar_no_words", 32'(acc_cnt), 32'd2);
    applyStimulus(16'd1);
    wait_done(20, 1'b0);
    checkOutput("ar_new_words", 32'(acc_cnt), 32'd1);
    checkOutput("ar_new_done", 32'(done_cnt), 32'd1);
    checkOutput("ar_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] fifo_valid never rises");
    fifo_valid = 1'b0;
    applyStimulus(16'd2);
`ifdef RESYNC_READER_TIMEOUT_EN
    wait_done(40, 1'b0);
    checkOutput("to_done_cycle", 32'(done_rel), 32'd17);
    checkOutput("to_error_at_done", 32'(error_at_done), 32'd1);
    checkOutput("to_error_sticky", 32'(error), 32'd1);
    checkOutput("to_re_count", 32'(re_cnt), 32'd0);
    resync_scoreboard();
    applyStimulus(16'd0);
    wait_done(10, 1'b0);
    checkOutput("to_error_cleared", 32'(error), 32'd0);
`else
    repeat (40) tick();
    checkOutput("nt_busy", 32'(busy), 32'd1);
    checkOutput("nt_error", 32'(error), 32'd0);
    checkOutput("nt_no_done", 32'(done_cnt), 32'd0);
    checkOutput("nt_re_count", 32'(re_cnt), 32'd0);
    srst = 1'b1;
    tick();
    srst = 1'b0;
    checkOutput("srst_busy", 32'(busy), 32'd0);
    checkOutput("srst_out_data", 32'(out_data), 32'(INIT_VAL));
    resync_scoreboard();
`endif

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/resync_reader.md
RESYNC_READER -- requirements
Module: resync_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of FIFO and output data.
REQ-002 Parameter LEN_WIDTH, default 16: width of burst length input and internal remaining counter.
REQ-003 Parameter INITIAL_VALUE, default 0: out_data value after reset.
REQ-004 Parameter TIMEOUT, default 1023: WAIT_VALID timeout in rclk cycles (used only with RESYNC_READER_TIMEOUT_EN).
REQ-005 rclk  input  1  single clock, positive edge; all logic SHALL use only this clock.
REQ-006 arst_n  input  1  reset, asynchronous, active-low.
REQ-007 srst  input  1  synchronous reset, active high, same effect as arst_n.
REQ-008 start  input  1  one-cycle burst request pulse.
REQ-009 len  input  LEN_WIDTH  number of words to read, sampled with start.
REQ-010 fifo_valid  input  1  FIFO "data valid" flag; once high it stays high until FIFO reset.
REQ-011 fifo_re  output  1  FIFO read enable.
REQ-012 fifo_data  input  DATA_WIDTH  FIFO registered output; valid on the cycle after fifo_re.
REQ-013 out_data  output  DATA_WIDTH  downstream data.
REQ-014 out_valid / out_ready  output / input  1 each  downstream handshake; transfer when both high.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse on burst completion.
REQ-017 error  output  1  sticky timeout flag, cleared by the next accepted start.

Function
REQ-018 FSM states: IDLE, WAIT_VALID, READ, DRAIN, DONE.
REQ-019 IDLE: start with len!=0 -> WAIT_VALID and load remaining=len; start with len==0 -> DONE, no fifo_re issued.
REQ-020 start outside IDLE SHALL be ignored.
REQ-021 WAIT_VALID: fifo_valid high -> READ on the next edge; fifo_re stays low in WAIT_VALID.
REQ-022 READ: fifo_re = (remaining!=0) and skid-buffer credit available; each fifo_re decrements remaining.
REQ-023 fifo_re SHALL be driven only from registered state, counters and out_ready; no other combinational input path.
REQ-024 Two-entry skid buffer; fifo_re is issued only when held entries + in-flight reads - pop in the current cycle <= 1, so the buffer never overflows.
REQ-025 fifo_data SHALL be captured into the skid buffer on the cycle after fifo_re, in order; out_data and out_valid SHALL be registered.
REQ-026 With out_ready held high, throughput SHALL be 1 word per cycle after the first word.
REQ-027 Latency: start at cycle 0 with fifo_valid high -> fifo_re first high at cycle 2 -> out_valid first high at cycle 4.
REQ-028 out_ready low SHALL freeze out_data/out_valid and stop fifo_re after at most 2 outstanding words.
REQ-029 READ -> DRAIN when remaining reaches 0; DRAIN -> DONE when skid empty and no read in flight.
REQ-030 DONE: done=1 for exactly one cycle, then IDLE.
REQ-031 Remaining counter SHALL NOT wrap; len = 2^LEN_WIDTH-1 SHALL be read in full.

Reset
REQ-032 arst_n low or srst high: state IDLE, remaining 0, skid empty, fifo_re 0, out_valid 0, out_data INITIAL_VALUE, busy 0, done 0, error 0.
REQ-033 Reset mid-burst SHALL abort without a done pulse; an in-flight fifo_data word SHALL be discarded.

Configuration
REQ-034 Macro RESYNC_READER_TIMEOUT_EN defined: a WAIT_VALID cycle counter runs; TIMEOUT cycles without fifo_valid -> DONE with error set; counter clears on leaving WAIT_VALID.
REQ-035 Macro RESYNC_READER_TIMEOUT_EN undefined: WAIT_VALID waits indefinitely; error tied to 0; no counter logic.

Verification
REQ-036 fifo_valid=1, out_ready=1, start len=4, FIFO words A,B,C,D -> out_valid cycles 4-7 carry A-D, exactly 4 fifo_re, done at cycle 8.
REQ-037 len=8, out_ready toggles 1,0,0,1 repeatedly -> 8 words in order, no loss or duplication, fifo_re never exceeds credit.
REQ-038 start len=0 -> no fifo_re, done 1 cycle later, busy high for one cycle only.
REQ-039 fifo_valid low for 20 cycles after start len=3 -> fifo_re stays 0 until 1 cycle after fifo_valid rises, then 3 words delivered.
REQ-040 arst_n low after 2 of 6 words -> outputs at reset values immediately, no done; a new start len=1 completes normally.
REQ-041 With RESYNC_READER_TIMEOUT_EN, TIMEOUT=15, fifo_valid=0 -> done and error at cycle 17; without the macro -> busy stays 1 and error stays 0.
